muldiv_unit: RTL and testbench

- Parametrised HI/LO multiply/divide unit for the EX stage, next to the single-cycle ALU decoder.
- Decodes its own OpCode/Funct for the HI/LO class: mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
- Runs multiply and divide iteratively, one operand bit per cycle, and owns the HI/LO registers.
- Raises a stall to the hazard unit while a HI/LO consumer must wait.

---
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: iterative shift-add multiply and restoring divide, HI/LO written WIDTH+1 edges after accept.
// Raises Stall for HI/LO instructions while Busy. Optional MULDIV_FAST_MUL_EN gives single-cycle mult/multu.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] HiLoOut,
  output logic             Busy,
  output logic             Stall,
  output logic             Done
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SAT  = CNT_W'(WIDTH);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   hi, lo, acc, q, opnd;
  logic [CNT_W-1:0]   cnt;
  logic               neg_res, neg_rem, div_op;

  logic rtype, op_mult, op_multu, op_div, op_divu, op_mfhi, op_mthi, op_mflo, op_mtlo;
  logic is_mul, is_div, is_hilo, idle, start_mul, start_div;

  assign rtype    = (OpCode == 6'd0);
  assign op_mult  = rtype && (Funct == 6'h18);
  assign op_multu = rtype && (Funct == 6'h19);
  assign op_div   = rtype && (Funct == 6'h1a);
  assign op_divu  = rtype && (Funct == 6'h1b);
  assign op_mfhi  = rtype && (Funct == 6'h10);
  assign op_mthi  = rtype && (Funct == 6'h11);
  assign op_mflo  = rtype && (Funct == 6'h12);
  assign op_mtlo  = rtype && (Funct == 6'h13);
  assign is_mul   = op_mult | op_multu;
  assign is_div   = op_div | op_divu;
  assign is_hilo  = is_mul | is_div | op_mfhi | op_mthi | op_mflo | op_mtlo;
  assign idle     = (state == IDLE);
  assign start_mul = Valid && idle && is_mul;
  assign start_div = Valid && idle && is_div;

  // Operand magnitudes and sign flags captured at the accepting edge
  logic             a_neg, b_neg, dz;
  logic [WIDTH-1:0] mag1, mag2;
  assign a_neg = (op_mult | op_div) && in1[WIDTH-1];
  assign b_neg = (op_mult | op_div) && in2[WIDTH-1];
  assign mag1  = a_neg ? -in1 : in1;
  assign mag2  = b_neg ? -in2 : in2;
  assign dz    = (in2 == '0);

  logic [WIDTH:0]     msum, dsh;
  logic               dge;
  logic [WIDTH-1:0]   dsub, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  assign msum     = {1'b0, acc} + {1'b0, (q[0] ? opnd : '0)};
  assign dsh      = {acc, q[WIDTH-1]};
  assign dge      = (dsh >= {1'b0, opnd});
  assign dsub     = dsh[WIDTH-1:0] - opnd;
  assign prod_fix = neg_res ? -{acc, q} : {acc, q};
  assign quo_fix  = neg_res ? -q : q;
  assign rem_fix  = neg_rem ? -acc : acc;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fprod;
  assign fprod = op_mult ? ({{WIDTH{in1[WIDTH-1]}}, in1} * {{WIDTH{in2[WIDTH-1]}}, in2})
                         : ({{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2});
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_div) state_nxt = DIV;
`ifndef MULDIV_FAST_MUL_EN
        else if (start_mul) state_nxt = MUL;
`endif
      end
      MUL:     if (cnt == LAST) state_nxt = FIX;
      DIV:     if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy    = !idle;
    Stall   = Valid && Busy && is_hilo;
    HiLoOut = '0;
    if (Valid && idle && op_mfhi)      HiLoOut = hi;
    else if (Valid && idle && op_mflo) HiLoOut = lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0; lo <= '0; acc <= '0; q <= '0; opnd <= '0; cnt <= '0;
      neg_res <= 1'b0; neg_rem <= 1'b0; div_op <= 1'b0; Done <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_div) begin
            // Divide by zero keeps the raw dividend so the remainder comes out as in1 unchanged
            opnd    <= mag2;
            q       <= dz ? in1 : mag1;
            acc     <= '0;
            cnt     <= '0;
            neg_res <= !dz && (a_neg ^ b_neg);
            neg_rem <= !dz && a_neg;
            div_op  <= 1'b1;
          end else if (start_mul) begin
`ifdef MULDIV_FAST_MUL_EN
            {hi, lo} <= fprod;
            Done     <= 1'b1;
`else
            opnd    <= mag1;
            q       <= mag2;
            acc     <= '0;
            cnt     <= '0;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= 1'b0;
            div_op  <= 1'b0;
`endif
          end else if (Valid && op_mthi) begin
            hi <= in1;
          end else if (Valid && op_mtlo) begin
            lo <= in1;
          end
        end
        MUL: begin
          acc <= msum[WIDTH:1];
          q   <= {msum[0], q[WIDTH-1:1]};
          if (cnt != SAT) cnt <= cnt + CNT_W'(1);
        end
        DIV: begin
          acc <= dge ? dsub : dsh[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], dge};
          if (cnt != SAT) cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          if (div_op) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: randomized HI/LO ops against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_ADD = 6'h20;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, Valid, Busy, Stall, Done;
  logic [5:0] OpCode, Funct;
  logic [W-1:0] in1, in2, HiLoOut;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .OpCode(OpCode), .Funct(Funct),
    .in1(in1), .in2(in2), .HiLoOut(HiLoOut), .Busy(Busy), .Stall(Stall), .Done(Done)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int acc_cyc = -100000;
  bit acc_fast = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] rd_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_hilo_f(input logic [5:0] op, input logic [5:0] f);
    return (op == 6'd0) && (f inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO});
  endfunction

  // Reference model: architectural HI/LO effect of each instruction in program order
  task automatic model_apply(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    int ia, ib;
    case (f)
      F_MULT:  begin sa = $signed(a); sb = $signed(b); {m_hi, m_lo} = sa * sb; end
      F_MULTU: begin ua = a; ub = b; {m_hi, m_lo} = ua * ub; end
      F_DIV: begin
        if (b == 0) begin m_hi = a; m_lo = '1; end
        else if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin m_hi = '0; m_lo = a; end
        else begin ia = a; ib = b; m_lo = ia / ib; m_hi = ia % ib; end
      end
      F_DIVU: begin
        if (b == 0) begin m_hi = a; m_lo = '1; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      F_MTHI: m_hi = a;
      F_MTLO: m_lo = a;
      F_MFHI: rd_q.push_back(m_hi);
      F_MFLO: rd_q.push_back(m_lo);
      default: ;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input logic [5:0] op, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    bit stalled;
    int n;
    if (op == 6'd0) model_apply(f, a, b);
    OpCode = op; Funct = f; in1 = a; in2 = b; Valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      stalled = Stall;
      @(posedge clk);
      #1;
      n++;
    end while (stalled && n < 200);
    if (stalled) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: still stalled after %0d cycles, expected acceptance", n);
    end
    if (op == 6'd0 && (f inside {F_MULT, F_MULTU, F_DIV, F_DIVU})) begin
      acc_cyc  = cyc;
      acc_fast = FAST && (f == F_MULT || f == F_MULTU);
    end
    Valid = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: Busy/Done/Stall timing from accept age, HiLoOut against the scoreboard
  always @(negedge clk) begin
    int age;
    bit eb, ed;
    if (!reset) begin
      age = cyc - acc_cyc + 1;
      eb  = !acc_fast && age >= 1 && age <= W + 1;
      ed  = acc_fast ? (age == 1) : (age == W + 2);
      check("busy", {31'b0, Busy}, {31'b0, eb});
      check("done", {31'b0, Done}, {31'b0, ed});
      check("stall", {31'b0, Stall}, {31'b0, Valid && eb && is_hilo_f(OpCode, Funct)});
      if (Valid && !Stall && OpCode == 6'd0 && (Funct == F_MFHI || Funct == F_MFLO)) begin
        if (rd_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL hilo_read: got %h with no expected read queued", HiLoOut);
        end else begin
          check("hilo_read", HiLoOut, rd_q.pop_front());
        end
      end else begin
        check("hilo_quiet", HiLoOut, '0);
      end
    end
  end

  initial begin
    reset = 1'b1; Valid = 1'b0; OpCode = '0; Funct = '0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    issue(6'd0, F_MFHI, 0, 0);
    issue(6'd0, F_MFLO, 0, 0);

    issue(6'd0, F_MULTU, 32'hffff_ffff, 32'd2);
    issue(6'd0, F_MFHI, 0, 0);
    issue(6'd0, F_MFLO, 0, 0);
    issue(6'd0, F_MULT, 32'hffff_fff9, 32'd3);
    issue(6'd0, F_MFHI, 0, 0);
    issue(6'd0, F_MFLO, 0, 0);
    issue(6'd0, F_DIV, 32'hffff_fff9, 32'd2);
    issue(6'd0, F_MFLO, 0, 0);
    issue(6'd0, F_MFHI, 0, 0);
    issue(6'd0, F_DIVU, 32'h10, 32'd0);
    issue(6'd0, F_MFLO, 0, 0);
    issue(6'd0, F_MFHI, 0, 0);
    issue(6'd0, F_DIV, 32'h8000_0000, 32'hffff_ffff);
    issue(6'd0, F_MFLO, 0, 0);
    issue(6'd0, F_MFHI, 0, 0);
    issue(6'd0, F_DIV, 32'hffff_fff9, 32'd0);
    issue(6'd0, F_MFHI, 0, 0);
    issue(6'd0, F_MFLO, 0, 0);
    issue(6'd0, F_MULTU, 32'd3, 32'd5);
    issue(6'd0, F_MFLO, 0, 0);

    // Back-to-back ops and a non-HI/LO instruction under Busy
    issue(6'd0, F_DIVU, 32'd100, 32'd7);
    issue(6'd0, F_ADD, 32'd1, 32'd1);
    issue(6'd0, F_MULT, 32'h8000_0000, 32'hffff_ffff);
    issue(6'd0, F_MFHI, 0, 0);
    issue(6'd0, F_MFLO, 0, 0);

    // Abort by reset mid-operation
    issue(6'd0, F_MULT, 32'd1234, 32'd5678);
    idle_cycles(10);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    acc_cyc = -100000; acc_fast = 1'b0; m_hi = '0; m_lo = '0;
    issue(6'd0, F_MFHI, 0, 0);
    issue(6'd0, F_MFLO, 0, 0);
    issue(6'd0, F_MTLO, 32'h1234, 0);
    issue(6'd0, F_MFLO, 0, 0);
    issue(6'd0, F_MTHI, 32'habcd, 0);
    issue(6'd0, F_MFHI, 0, 0);

    // Bubbles and non-zero opcodes carrying mult funct must stay quiet
    OpCode = '0; Funct = F_MULT; in1 = 32'd9; in2 = 32'd9; Valid = 1'b0;
    idle_cycles(4);
    issue(6'h23, F_MULT, 32'd9, 32'd9);
    issue(6'h08, F_MTHI, 32'd77, 0);
    issue(6'd0, F_MFHI, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 10);
      case (r)
        0: issue(6'd0, F_MULT,  rnd_opnd(), rnd_opnd());
        1: issue(6'd0, F_MULTU, rnd_opnd(), rnd_opnd());
        2: issue(6'd0, F_DIV,   rnd_opnd(), rnd_opnd());
        3: issue(6'd0, F_DIVU,  rnd_opnd(), rnd_opnd());
        4: issue(6'd0, F_MFHI, 0, 0);
        5: issue(6'd0, F_MFLO, 0, 0);
        6: issue(6'd0, F_MTHI, W'($urandom), 0);
        7: issue(6'd0, F_MTLO, W'($urandom), 0);
        8: issue(6'd0, F_ADD, W'($urandom), W'($urandom));
        9: issue(6'h23, F_DIV, W'($urandom), W'($urandom));
        default: begin
          OpCode = '0; Funct = F_DIVU; Valid = 1'b0;
          idle_cycles($urandom_range(1, 5));
        end
      endcase
      if ($urandom_range(0, 1) == 1) issue(6'd0, F_MFHI, 0, 0);
      if ($urandom_range(0, 1) == 1) issue(6'd0, F_MFLO, 0, 0);
    end

    idle_cycles(40);
    check("rd_q_drained", W'(rd_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
